click_counter: RTL and testbench



---
 rtl/click_counter_pkg.sv | 15 +
 rtl/click_window_timer.sv | 35 +++
 rtl/click_counter.sv | 107 ++++++++++
 tb/tb_click_counter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/click_counter_pkg.sv
// Shared types and helpers for the click burst counter.
// The window helper is used by both the RTL and its testbench so they agree on cycle counts.
package click_counter_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    COUNTING = 1'b1
  } click_state_t;

  // Rounds up so a window shorter than one clock still spans a full cycle.
  function automatic int calc_window_cycles(input int freq_mhz, input int window_ns);
    return (freq_mhz * window_ns + 999) / 1000;
  endfunction

endpackage

// File: rtl/click_window_timer.sv
// Down-counter measuring the inter-press gap; reloads to WINDOW_CYCLES-1 and
// saturates at zero so the owner can poll zero_o without extra guarding.
module click_window_timer #(
  parameter int WINDOW_CYCLES = 30,
  localparam int TW = $clog2(WINDOW_CYCLES + 1)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic dec_i,
  output logic zero_o
);

  logic [TW-1:0] timer_q, timer_d;

  always_comb begin
    timer_d = timer_q;
    if (load_i) begin
      timer_d = TW'(WINDOW_CYCLES - 1);
    end else if (dec_i && (timer_q != '0)) begin
      timer_d = timer_q - TW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

  assign zero_o = (timer_q == '0);

endmodule

// File: rtl/click_counter.sv
// Groups debounced press strobes into bursts and reports the burst size as a
// one-cycle registered count/valid pair.
module click_counter
  import click_counter_pkg::*;
#(
  parameter int CLK_FREQ_MHZ    = 100,
  parameter int CLICK_WINDOW_NS = 300,
  parameter int MAX_CLICKS      = 3,
  localparam int WINDOW_CYCLES  = calc_window_cycles(CLK_FREQ_MHZ, CLICK_WINDOW_NS),
  localparam int CNT_W          = $clog2(MAX_CLICKS + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             press_stb_i,
  output logic             click_valid_o,
  output logic [CNT_W-1:0] click_cnt_o,
  output logic             busy_o
);

  click_state_t     state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] count_inc;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_out_q, cnt_out_d;
  logic             timer_load, timer_dec, timer_zero;

  click_window_timer #(
    .WINDOW_CYCLES(WINDOW_CYCLES)
  ) u_timer (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load_i (timer_load),
    .dec_i  (timer_dec),
    .zero_o (timer_zero)
  );

  // count_q stays below MAX_CLICKS while COUNTING, so the increment cannot wrap.
  assign count_inc = count_q + CNT_W'(1);

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    valid_d    = 1'b0;
    cnt_out_d  = '0;
    timer_load = 1'b0;
    timer_dec  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (press_stb_i) begin
          timer_load = 1'b1;
          if (MAX_CLICKS == 1) begin
            valid_d   = 1'b1;
            cnt_out_d = CNT_W'(1);
            count_d   = '0;
          end else begin
            count_d = CNT_W'(1);
            state_d = COUNTING;
          end
        end
      end
      COUNTING: begin
        // A strobe takes priority over an expiring window.
        if (press_stb_i) begin
          timer_load = 1'b1;
          if (count_inc == CNT_W'(MAX_CLICKS)) begin
            valid_d   = 1'b1;
            cnt_out_d = count_inc;
            count_d   = '0;
            state_d   = IDLE;
          end else begin
            count_d = count_inc;
          end
        end else if (timer_zero) begin
          valid_d   = 1'b1;
          cnt_out_d = count_q;
          count_d   = '0;
          state_d   = IDLE;
        end else begin
          timer_dec = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      count_q   <= '0;
      valid_q   <= 1'b0;
      cnt_out_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      valid_q   <= valid_d;
      cnt_out_q <= cnt_out_d;
    end
  end

  assign click_valid_o = valid_q;
  assign click_cnt_o   = cnt_out_q;
  assign busy_o        = (state_q == COUNTING);

endmodule

// File: tb/tb_click_counter.sv
// Scoreboard bench for click_counter at default parameters: drivers push the
// expected burst (closing edge, count) and a negedge monitor pops on every valid.
module tb_click_counter;
  import click_counter_pkg::*;

  localparam int W     = calc_window_cycles(100, 300);
  localparam int MAXC  = 3;
  localparam int CNT_W = $clog2(MAXC + 1);

  typedef struct {
    int              edge_n;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             press;
  logic             click_valid;
  logic [CNT_W-1:0] click_cnt;
  logic             busy;

  exp_t exp_q[$];
  int   cyc;
  int   tests;
  int   fails;
  int   strobes_sent;
  int   presses_seen;

  click_counter dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .press_stb_i   (press),
    .click_valid_o (click_valid),
    .click_cnt_o   (click_cnt),
    .busy_o        (busy)
  );

  // Clock and edge counter: cyc holds the number of rising edges seen so far.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input int edge_n, input int cnt);
    exp_t e;
    e.edge_n = edge_n;
    e.cnt    = CNT_W'(cnt);
    exp_q.push_back(e);
  endtask

  // Drivers: all called from negedge context.
  task automatic wait_cyc(input int e);
    while (cyc < e) @(negedge clk);
  endtask

  task automatic pulse_at(input int e);
    wait_cyc(e - 1);
    press = 1'b1;
    strobes_sent++;
    @(negedge clk);
    press = 1'b0;
  endtask

  task automatic drain(input string name);
    int budget;
    budget = 4 * W;
    while (exp_q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check(name, exp_q.size(), 0);
    repeat (W + 5) @(negedge clk);
  endtask

  // Monitor: pops one expectation per valid pulse; cnt must idle at zero.
  always @(negedge clk) begin
    if (rst_n) begin
      if (click_valid) begin
        presses_seen += int'(click_cnt);
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("valid_edge", cyc, e.edge_n);
          check("valid_cnt", int'(click_cnt), int'(e.cnt));
        end
      end else if (click_cnt != '0) begin
        check("idle_cnt_zero", int'(click_cnt), 0);
      end
    end
  end

  initial begin
    int base;
    int e;
    int last;
    int count;
    cyc = 0; tests = 0; fails = 0; strobes_sent = 0; presses_seen = 0;
    press = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_valid", int'(click_valid), 0);
    check("reset_cnt", int'(click_cnt), 0);
    check("reset_busy", int'(busy), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single press: closes W edges later with cnt=1.
    base = cyc;
    push_exp(base + 10 + W, 1);
    wait_cyc(base + 9);
    check("t1_busy_before", int'(busy), 0);
    pulse_at(base + 10);
    check("t1_busy_first", int'(busy), 1);
    wait_cyc(base + 10 + W - 1);
    check("t1_busy_last", int'(busy), 1);
    wait_cyc(base + 10 + W);
    check("t1_busy_emit", int'(busy), 0);
    drain("t1_drain");

    // Gap of exactly W stays in the same burst.
    base = cyc;
    push_exp(base + 10 + 2 * W, 2);
    pulse_at(base + 10);
    pulse_at(base + 10 + W);
    drain("t2_drain");

    // Gap of W+1 splits into two bursts.
    base = cyc;
    push_exp(base + 10 + W, 1);
    push_exp(base + 11 + 2 * W, 1);
    pulse_at(base + 10);
    pulse_at(base + 11 + W);
    drain("t3_drain");

    // Back-to-back strobes hit MAX, then a strobe during valid starts a new burst.
    base = cyc;
    push_exp(base + 12, 3);
    push_exp(base + 13 + W, 1);
    pulse_at(base + 10);
    pulse_at(base + 11);
    pulse_at(base + 12);
    check("t4_busy_at_valid", int'(busy), 0);
    pulse_at(base + 13);
    check("t4_busy_new_burst", int'(busy), 1);
    drain("t4_drain");

    // Reset mid-burst discards the burst with no emission.
    base = cyc;
    pulse_at(base + 10);
    wait_cyc(base + 24);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_busy", int'(busy), 0);
    check("t5_rst_valid", int'(click_valid), 0);
    check("t5_rst_cnt", int'(click_cnt), 0);
    wait_cyc(base + 26);
    rst_n = 1'b1;
    strobes_sent--;
    repeat (3 * W) @(negedge clk);
    check("t5_no_emit", exp_q.size(), 0);

    // Random gaps in 1..2W; the burst model pushes each closure before it is due.
    last = cyc;
    count = 0;
    for (int i = 0; i < 300; i++) begin
      e = last + $urandom_range(2 * W, 1);
      if (count > 0 && (e - last) > W) begin
        push_exp(last + W, count);
        count = 0;
      end
      count++;
      if (count == MAXC) begin
        push_exp(e, count);
        count = 0;
      end
      pulse_at(e);
      last = e;
    end
    if (count > 0) push_exp(last + W, count);
    drain("rand_drain");
    check("press_total", presses_seen, strobes_sent);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
